seven_segment_reader: RTL and testbench
=======================================

// Module: seven_segment_reader
// PURPOSE
//  Receive end of the multiplexed seven-segment display interface: samples segment lines plus
//  active-low digit enables and decodes each lit pattern back to a hex nibble.
//  Assembles one word per full scan and reports it with a 1-cycle valid pulse.
//  Sits between a display driver's pins (or a board loop-back) and downstream checking logic.
// PARAMETERS
//  N_DIGITS        4      digits per scan; digit 0 = an_n[0] = least-significant nibble
//  STABLE_CYCLES   16     consecutive identical samples required before a digit is captured
//  TIMEOUT_CYCLES  65536  cycles from first capture of a frame before an incomplete frame is dropped
// PORTS
//  clk      in   1            single clock, all logic rising-edge
//  rst_n    in   1            reset, synchronous, active-low
//  seg      in   7            segment lines, active-high, bit0=a .. bit6=g (async to clk)
//  an_n     in   N_DIGITS     digit enables, active-low, one-hot-low when a digit is lit (async)
//  value    out  4*N_DIGITS   last complete decoded word
//  blank    out  N_DIGITS     per-digit: pattern was 0x00 in last frame (nibble reads 0)
//  valid    out  1            1-cycle pulse: value/blank/err updated this cycle
//  err      out  1            valid with this pulse: >=1 digit had an unrecognised pattern
//  timeout  out  1            1-cycle pulse: partial frame discarded
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): value=0, blank=0, valid=0, err=0, timeout=0; captured/bad
//    flags cleared; counters 0; synchroniser flops load seg=0, an_n=all-1. Partial frame lost.
//  - seg and an_n pass a 2-flop synchroniser; all decisions use synchronised copies (2-cycle skew).
//  - Active digit idx defined only when exactly one an_n bit is low; zero/multiple low = no digit,
//    stability counter held at 0.
//  - Stability counter (width $clog2(STABLE_CYCLES+1)) increments while {idx,seg} equals previous
//    cycle, clears to 0 on any change; saturates at STABLE_CYCLES.
//  - Capture when counter reaches STABLE_CYCLES-1 and digit idx not yet captured this frame: store
//    decoded nibble, blank bit (seg==0x00), bad bit (unrecognised); set captured[idx]. One capture per
//    dwell; later dwells on an already-captured digit ignored (first capture wins).
//  - Decode table (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07|27 8=7F 9=6F|67 A=77 b=7C
//    C=39 d=5E E=79 F=71; 0x00=blank; all other patterns = bad, nibble 0.
//  - FSM: IDLE (no captures) -> COLLECT on first capture (timeout counter starts at 0);
//    COLLECT -> PUBLISH when all captured bits set; PUBLISH (1 cycle): valid=1, value/blank load,
//    err=OR(bad), captured/bad cleared -> IDLE. Latency: valid 1 cycle after last capture edge.
//  - COLLECT timeout counter reaching TIMEOUT_CYCLES-1: timeout=1 one cycle, captured/bad cleared,
//    value/blank unchanged, -> IDLE. Completion on same cycle as timeout: completion wins.
//  - A capture coinciding with PUBLISH is applied to the new frame (goes IDLE->COLLECT directly).
//  - value/blank hold between frames; err/valid/timeout are pulses, 0 otherwise.
// STRUCTURE
//  - Package seg7_pkg: segment bit-order constants, SEG_HEX table localparams, SEG_BLANK=7'h00,
//    FSM state typedef {IDLE,COLLECT,PUBLISH}; shared with the display driver.
//  - Sub-module seg7_pattern_decode: combinational seg[6:0] -> {nibble, blank, bad}.
//  - Top: synchroniser, stability counter, capture regs, FSM, timeout counter.
// TESTING
//  1 Reset: activity on seg/an_n with rst_n=0 for 5 cycles -> all outputs 0, no valid.
//  2 Scan an_n=1110/1101/1011/0111 with 06/5B/4F/66, 32 cycles each -> one valid, value=16'h4321, err=0.
//  3 seg toggles 06<->5B every 8 cycles on digit 0 -> no capture, no valid, no timeout.
//  4 Full scan with digit2=0x49 -> valid, err=1, value[11:8]=0, blank=0; 9 as 0x67 decodes 9.
//  5 Scan digits 0,1 only then an_n=1111 -> timeout pulse TIMEOUT_CYCLES after first capture, value held.
//  6 digit3=0x00 -> blank=4'b1000, value[15:12]=0; rst_n pulsed after 2 captures then full scan -> exactly one valid.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment ordering, glyph table and reader FSM states.
// Used by both the display driver and the receive-side reader.
package seg7_pkg;

  // Segment vectors are {g,f,e,d,c,b,a}: bit 0 is segment a, bit 6 is segment g.
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam logic [SEG_W-1:0] SEG_HEX_7_ALT = 7'h27;
  localparam logic [SEG_W-1:0] SEG_HEX_9_ALT = 7'h67;
  localparam logic [SEG_W-1:0] SEG_BLANK     = 7'h00;

  typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
// Blank patterns read as nibble 0; unrecognised patterns flag bad and read as 0.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [3:0]       nibble,
  output logic             blank,
  output logic             bad
);

  always_comb begin
    nibble = 4'h0;
    blank  = (seg == SEG_BLANK);
    bad    = !blank;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_HEX[i]) begin
        nibble = 4'(i);
        bad    = 1'b0;
      end
    end
    // Drivers differ on whether 7 lights segment f and 9 lights segment d.
    if (seg == SEG_HEX_7_ALT) begin
      nibble = 4'h7;
      bad    = 1'b0;
    end
    if (seg == SEG_HEX_9_ALT) begin
      nibble = 4'h9;
      bad    = 1'b0;
    end
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Receive side of a multiplexed seven-segment display: synchronises the pins, waits for each
// digit to settle, decodes it, and publishes one word per complete scan.
module seven_segment_reader
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEG_W-1:0]      seg,
  input  logic [N_DIGITS-1:0]   an_n,
  output logic [4*N_DIGITS-1:0] value,
  output logic [N_DIGITS-1:0]   blank,
  output logic                  valid,
  output logic                  err,
  output logic                  timeout
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [SEG_W-1:0]    seg_p0, seg_p1, seg_p2;
  logic [N_DIGITS-1:0] an_p0, an_p1;
  logic                digit_ok;
  logic [IDX_W-1:0]    digit_idx, idx_p2;
  logic                ok_p2;
  logic [CNT_W-1:0]    stab_cnt;

  logic [3:0]          dec_nib;
  logic                dec_blank, dec_bad;
  logic                capture_ev;

  logic [N_DIGITS-1:0]      captured, captured_nxt, bad_flags, bad_nxt;
  logic [N_DIGITS-1:0][3:0] frame_nib;
  logic [N_DIGITS-1:0]      frame_blank;
  logic                     err_q;

  seg7_state_e      state, state_nxt;
  logic [TO_W-1:0]  to_cnt;
  logic             all_cap, to_hit;

  // Stage p0/p1: two-flop synchroniser on the asynchronous display pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_p0 <= '0;
      seg_p1 <= '0;
      an_p0  <= '1;
      an_p1  <= '1;
    end else begin
      seg_p0 <= seg;
      seg_p1 <= seg_p0;
      an_p0  <= an_n;
      an_p1  <= an_p0;
    end
  end

  always_comb begin
    digit_ok  = 1'b0;
    digit_idx = '0;
    if ($onehot(~an_p1)) begin
      digit_ok = 1'b1;
      for (int i = 0; i < N_DIGITS; i++) begin
        if (!an_p1[i]) digit_idx = IDX_W'(i);
      end
    end
  end

  // Stage p2: stab_cnt counts how many times the sample now held in p2 repeated its predecessor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_p2   <= '0;
      idx_p2   <= '0;
      ok_p2    <= 1'b0;
      stab_cnt <= '0;
    end else begin
      seg_p2 <= seg_p1;
      idx_p2 <= digit_idx;
      ok_p2  <= digit_ok;
      if (digit_ok && ok_p2 && digit_idx == idx_p2 && seg_p1 == seg_p2) begin
        if (stab_cnt != CNT_W'(STABLE_CYCLES)) stab_cnt <= stab_cnt + 1'b1;
      end else begin
        stab_cnt <= '0;
      end
    end
  end

  seg7_pattern_decode u_decode (
    .seg    (seg_p2),
    .nibble (dec_nib),
    .blank  (dec_blank),
    .bad    (dec_bad)
  );

  // The counter passes STABLE_CYCLES-1 only once per dwell, which limits each dwell to one capture.
  assign capture_ev = ok_p2 && (stab_cnt == CNT_W'(STABLE_CYCLES - 1)) && !captured[idx_p2];
  assign all_cap    = &captured;
  assign to_hit     = (state == COLLECT) && !all_cap && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    captured_nxt = captured;
    bad_nxt      = bad_flags;
    if (state == PUBLISH || to_hit) begin
      captured_nxt = '0;
      bad_nxt      = '0;
    end
    if (capture_ev && !to_hit) begin
      captured_nxt[idx_p2] = 1'b1;
      bad_nxt[idx_p2]      = dec_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      captured  <= '0;
      bad_flags <= '0;
    end else begin
      captured  <= captured_nxt;
      bad_flags <= bad_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (capture_ev && !to_hit) begin
      frame_nib[idx_p2]   <= dec_nib;
      frame_blank[idx_p2] <= dec_blank;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      to_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state != COLLECT) to_cnt <= '0;
      else                  to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture_ev) state_nxt = COLLECT;
      COLLECT: begin
        if (all_cap)     state_nxt = PUBLISH;
        else if (to_hit) state_nxt = IDLE;
      end
      PUBLISH: state_nxt = capture_ev ? COLLECT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The word registers load on the edge that enters PUBLISH, so they are current while valid is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
      blank <= '0;
      err_q <= 1'b0;
    end else if (state == COLLECT && all_cap) begin
      value <= frame_nib;
      blank <= frame_blank;
      err_q <= |bad_flags;
    end
  end

  always_comb begin
    valid   = (state == PUBLISH);
    err     = valid && err_q;
    timeout = to_hit;
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader: scans digit patterns and checks the published words.
module tb_seven_segment_reader;

  localparam int N_DIGITS = 4;
  localparam int STABLE   = 16;
  localparam int TMO      = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an_n;
  logic [15:0] value;
  logic [3:0]  blank;
  logic        valid, err, timeout;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int to_cnt = 0;
  int to_cyc = 0;
  logic [15:0] last_val = '0;
  logic [3:0]  last_blank = '0;
  logic        last_err = 1'b0;

  seven_segment_reader #(
    .N_DIGITS       (N_DIGITS),
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg     (seg),
    .an_n    (an_n),
    .value   (value),
    .blank   (blank),
    .valid   (valid),
    .err     (err),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt  = valid_cnt + 1;
      last_val   = value;
      last_blank = blank;
      last_err   = err;
    end
    if (timeout) begin
      to_cnt = to_cnt + 1;
      to_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] s, input int n);
    an_n = an;
    seg  = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    dwell(4'b1110, s0, 32);
    dwell(4'b1101, s1, 32);
    dwell(4'b1011, s2, 32);
    dwell(4'b0111, s3, 32);
    dwell(4'b1111, 7'h00, 10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_v, base_t, t0;

    // Reset with live pin activity
    rst_n = 1'b0;
    an_n  = 4'b1110;
    seg   = 7'h06;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_blank", 32'(blank), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    an_n  = 4'b1111;
    seg   = 7'h00;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Basic scan 1,2,3,4
    base_v = valid_cnt;
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);
    chk("scan_valid_cnt", 32'(valid_cnt - base_v), 32'd1);
    chk("scan_value", 32'(last_val), 32'h4321);
    chk("scan_err", 32'(last_err), 32'h0);
    chk("scan_blank", 32'(last_blank), 32'h0);

    // Unstable digit never settles
    base_v = valid_cnt;
    base_t = to_cnt;
    for (int i = 0; i < 8; i++) dwell(4'b1110, (i % 2 == 0) ? 7'h06 : 7'h5B, 8);
    dwell(4'b1111, 7'h00, TMO + 50);
    chk("toggle_valid_cnt", 32'(valid_cnt - base_v), 32'd0);
    chk("toggle_timeout_cnt", 32'(to_cnt - base_t), 32'd0);
    chk("toggle_value_hold", 32'(value), 32'h4321);

    // Bad pattern on digit 2, alternate 9 glyph on digit 0
    base_v = valid_cnt;
    scan(7'h67, 7'h5B, 7'h49, 7'h7C);
    chk("bad_valid_cnt", 32'(valid_cnt - base_v), 32'd1);
    chk("bad_value", 32'(last_val), 32'hB029);
    chk("bad_nibble", 32'(last_val[11:8]), 32'h0);
    chk("alt9_nibble", 32'(last_val[3:0]), 32'h9);
    chk("bad_err", 32'(last_err), 32'h1);
    chk("bad_blank", 32'(last_blank), 32'h0);

    // Partial frame times out
    base_v = valid_cnt;
    base_t = to_cnt;
    t0 = cyc;
    dwell(4'b1110, 7'h3F, 32);
    dwell(4'b1101, 7'h06, 32);
    dwell(4'b1111, 7'h00, TMO + 40);
    chk("tmo_pulse_cnt", 32'(to_cnt - base_t), 32'd1);
    chk("tmo_valid_cnt", 32'(valid_cnt - base_v), 32'd0);
    chk("tmo_latency_ok", 32'((to_cyc - t0) >= TMO + 10 && (to_cyc - t0) <= TMO + 30), 32'd1);
    chk("tmo_value_hold", 32'(value), 32'hB029);
    chk("tmo_blank_hold", 32'(blank), 32'h0);

    // Blank digit 3, alternate 7 glyph on digit 2
    base_v = valid_cnt;
    scan(7'h3F, 7'h7F, 7'h27, 7'h00);
    chk("blank_valid_cnt", 32'(valid_cnt - base_v), 32'd1);
    chk("blank_value", 32'(last_val), 32'h0780);
    chk("blank_mask", 32'(last_blank), 32'h8);
    chk("blank_err", 32'(last_err), 32'h0);

    // Reset mid-frame, then a full scan
    base_v = valid_cnt;
    dwell(4'b1110, 7'h77, 32);
    dwell(4'b1101, 7'h39, 32);
    rst_n = 1'b0;
    dwell(4'b1111, 7'h00, 2);
    rst_n = 1'b1;
    chk("midrst_value", 32'(value), 32'h0);
    chk("midrst_blank", 32'(blank), 32'h0);
    dwell(4'b1111, 7'h00, 4);
    scan(7'h77, 7'h39, 7'h5E, 7'h71);
    chk("midrst_valid_cnt", 32'(valid_cnt - base_v), 32'd1);
    chk("midrst_scan_value", 32'(last_val), 32'hFDCA);
    chk("midrst_value_hold", 32'(value), 32'hFDCA);
    chk("midrst_valid_idle", 32'(valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
